stream_buffer: RTL and testbench
================================

# stream_buffer

Parametrised circular FIFO with configurable data width and depth, a push interface for producers that cannot stall, and a valid/ready pop interface. It replaces the fixed 8-bit directional buffer between byte-stream peripherals (UART/SPI receive and transmit paths) and their consumers. It adds occupancy reporting, an almost-full threshold, synchronous flush, a per-write overflow pulse and optional drop statistics.

## Interface
- DATA_WIDTH, 8: width of each entry in bits.
- DEPTH, 16: number of entries; must be a power of 2 and at least 2.
- ADDR_WIDTH, $clog2(DEPTH): pointer width; derived, do not override.
- ALMOST_FULL_LVL, DEPTH-2: `almost_full` asserts when `count` >= this value; legal range is 1..DEPTH.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous empty request.
- in_valid  in  1  push strobe; data is written if there is room.
- in_data  in  DATA_WIDTH  push data.
- in_ready  out  1  high when the FIFO is not full; informational only, producers are not required to wait on it.
- overflow  out  1  one-cycle registered pulse marking a discarded push.
- out_valid  out  1  high when `count` is non-zero.
- out_data  out  DATA_WIDTH  head entry, first-word-fall-through.
- out_ready  in  1  consumer accepts the head entry.
- count  out  ADDR_WIDTH+1  number of entries stored.
- free  out  ADDR_WIDTH+1  free entries, equal to DEPTH minus `count`.
- almost_full  out  1  `count` >= ALMOST_FULL_LVL.
- drop_count  out  16  saturating count of discarded pushes (see Configuration).

## Operation
- pop = out_valid && out_ready. push_ok = in_valid && (count < DEPTH || pop).
- A push writes mem[wr_ptr], then wr_ptr increments. A pop increments rd_ptr. Both pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Count update:
  - push_ok only: count +1.
  - pop only: count −1.
  - both: count unchanged.
  - neither: count unchanged.
- Full with a simultaneous pop: the push is accepted and count stays at DEPTH.
- Empty with a simultaneous push: no pop is possible. Count becomes 1 on the next cycle; data does not bypass combinationally.
- Full without a pop: the push is discarded, `overflow` pulses on the next cycle, and the drop counter increments.
- `out_ready` while `out_valid`=0 has no effect.
- flush:
  - Pointers and count go to 0.
  - Any push or pop in the same cycle is ignored.
  - Storage is not cleared.
  - `drop_count` is not cleared.
- reset: pointers, count, storage, `overflow` and `drop_count` all go to 0. Priority is reset > flush > push/pop.

## Timing
- Values after reset:
  - out_valid=0, out_data=0, count=0, free=DEPTH.
  - in_ready=1, almost_full=0, overflow=0, drop_count=0.
- Write-to-read latency is 1 cycle: data pushed in cycle N is visible on `out_data` with `out_valid`=1 in cycle N+1.
- `out_data` is a combinational read of mem[rd_ptr]. It is meaningful only while `out_valid`=1.
- The in_ready, out_valid, count, free and almost_full outputs are decoded from registered state. No output depends combinationally on `in_valid` or `out_ready`.
- Reset asserted mid-stream takes effect at the next edge; any push or pop in that cycle is lost.

## Configuration
- STREAM_BUFFER_DROP_CNT_EN defined:
  - `drop_count` is a 16-bit register.
  - It increments on each discarded push and saturates at 0xFFFF.
  - It is cleared only by reset.
- Not defined:
  - `drop_count` is tied to 0 and no counter logic is built.
  - `overflow` still operates.

## Structure
- Package stream_buffer_pkg holds DROP_CNT_WIDTH = 16 and DROP_CNT_MAX = 16'hFFFF.
- One sub-module, stream_buffer_ram: DEPTH×DATA_WIDTH register array with one synchronous write port, an asynchronous read port, and synchronous reset-to-zero.
- Pointer, count, flag and drop logic sit in the top module.

## Test plan
Bench configuration: DEPTH=4, DATA_WIDTH=8, ALMOST_FULL_LVL=3.
- Reset, then hold idle → out_valid=0, count=0, free=4, in_ready=1, drop_count=0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then pop 4 → out_data sequence 0x11..0x44; almost_full=1 at count 3; in_ready=0 at count 4.
- Fill with 0xA0..0xA3, then push 0xFF with no pop → 0xFF discarded; overflow pulses once; drop_count=1 with the macro and 0 without; head is still 0xA0.
- Full, then push 0xB4 with a simultaneous pop → 0xA0 leaves, count stays 4; after 10 push+pop cycles the pointers have wrapped and order is preserved.
- Empty, push 0x5A with out_ready=1 held → out_valid=0 in the push cycle, then 1 the next cycle with out_data=0x5A; it pops on that cycle.
- Count 3, flush with a simultaneous push and pop → count=0, out_valid=0 next cycle, drop_count unchanged; 0x77 pushed afterwards becomes the new head.

Source files
------------

// File: rtl/stream_buffer_pkg.sv
// Shared constants for the stream_buffer FIFO: drop statistics width and saturation value.
package stream_buffer_pkg;

  localparam int DROP_CNT_WIDTH = 16;
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/stream_buffer_ram.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, asynchronous read,
// synchronous clear-to-zero on reset.
module stream_buffer_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_buffer.sv
// Circular FIFO with non-stalling push, valid/ready pop, occupancy flags and flush.
// Optional saturating drop statistics enabled by defining STREAM_BUFFER_DROP_CNT_EN.
module stream_buffer
  import stream_buffer_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int DEPTH           = 16,
  parameter int ADDR_WIDTH      = $clog2(DEPTH),
  parameter int ALMOST_FULL_LVL = DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  output logic                      overflow,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH:0]       count,
  output logic [ADDR_WIDTH:0]       free,
  output logic                      almost_full,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL_C = (ADDR_WIDTH + 1)'(ALMOST_FULL_LVL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  full, pop, push_ok, drop_evt;

  // Handshakes: the pop side transfers when out_valid && out_ready on a rising edge;
  // the push side never stalls, so in_valid with no room is dropped and flagged.
  assign full     = (count_q == DEPTH_C);
  assign pop      = out_valid && out_ready && !flush;
  assign push_ok  = in_valid && (!full || (out_valid && out_ready)) && !flush;
  assign drop_evt = in_valid && !flush && !push_ok;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = drop_evt;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  stream_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

  assign out_valid   = (count_q != '0);
  assign in_ready    = !full;
  assign count       = count_q;
  assign free        = DEPTH_C - count_q;
  assign almost_full = (count_q >= AF_LVL_C);
  assign overflow    = overflow_q;

`ifdef STREAM_BUFFER_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (drop_evt && (drop_q != DROP_CNT_MAX)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_stream_buffer.sv
// Bench for stream_buffer (DEPTH=4, DATA_WIDTH=8, ALMOST_FULL_LVL=3): directed cases then
// random traffic, every cycle compared against a queue-based model of the FIFO.
module tb_stream_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int AF    = 3;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, overflow, out_valid, almost_full;
  logic [DW-1:0] out_data;
  logic [AW:0]   count, free;
  logic [15:0]   drop_count;

  stream_buffer #(
    .DATA_WIDTH      (DW),
    .DEPTH           (DEPTH),
    .ALMOST_FULL_LVL (AF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .overflow    (overflow),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .free        (free),
    .almost_full (almost_full),
    .drop_count  (drop_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic          exp_ovf;
  int            exp_drop;
  logic          mem_zero;
  int            n_vec;
  int            n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check("count",       32'(count),       32'(sz));
    check("free",        32'(free),        32'(DEPTH - sz));
    check("out_valid",   32'(out_valid),   32'(sz != 0));
    check("in_ready",    32'(in_ready),    32'(sz != DEPTH));
    check("almost_full", 32'(almost_full), 32'(sz >= AF));
    check("overflow",    32'(overflow),    32'(exp_ovf));
    check("drop_count",  32'(drop_count),  32'(exp_drop));
    if (sz != 0)       check("out_data", 32'(out_data), 32'(exp_q[0]));
    else if (mem_zero) check("out_data_rst", 32'(out_data), 32'h0);
  endtask

  // Behavioural FIFO: a queue that accepts while below DEPTH (or while the head leaves).
  task automatic model_step(input logic rst, input logic fl, input logic iv,
                            input logic [DW-1:0] d, input logic ordy);
    logic do_pop, do_push;
    if (rst) begin
      exp_q.delete();
      exp_ovf  = 1'b0;
      exp_drop = 0;
      mem_zero = 1'b1;
    end else if (fl) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      do_pop  = (exp_q.size() > 0) && ordy;
      do_push = iv && ((exp_q.size() < DEPTH) || do_pop);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(d);
        mem_zero = 1'b0;
      end
      exp_ovf = iv && !do_push;
`ifdef STREAM_BUFFER_DROP_CNT_EN
      if (exp_ovf && exp_drop < 65535) exp_drop++;
`endif
    end
  endtask

  // driver: apply one cycle of inputs at the falling edge, check, then advance the model
  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [DW-1:0] d, input logic ordy);
    @(negedge clk);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    check_outputs();
    model_step(rst, fl, iv, d, ordy);
  endtask

  task automatic push(input logic [DW-1:0] d);
    drive(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic pop_one();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0; exp_drop = 0; mem_zero = 1'b1;
    repeat (2) @(posedge clk);

    // reset state, idle
    idle(); idle();

    // in-order fill and drain
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (4) pop_one();
    idle();

    // overflow while full
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
    push(8'hFF);
    idle(); idle();

    // full with simultaneous push+pop, then pointer wrap
    drive(1'b0, 1'b0, 1'b1, 8'hB4, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b1);
    repeat (4) pop_one();
    idle();

    // empty push with out_ready held: no bypass, pops the following cycle
    drive(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle();

    // flush at count 3 with simultaneous push and pop
    push(8'h01); push(8'h02); push(8'h03);
    drive(1'b0, 1'b1, 1'b1, 8'h99, 1'b1);
    idle();
    push(8'h77);
    idle();
    pop_one();

    // reset mid-stream discards the push/pop in that cycle
    push(8'h10); push(8'h20);
    drive(1'b1, 1'b0, 1'b1, 8'h30, 1'b1);
    idle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) < 7),
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 9) < 4));
    end
    repeat (2) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
